load_fire_unit: RTL and testbench

- Downstream consumer of the load queue. Each cycle it selects the oldest load that is eligible to fire, using the LDQ's head-rotated status vectors.
- It holds the selected load in a one-entry issue register. The store-queue searcher resolves that load combinationally (sleep, forward, or go to memory).
- The unit then drives the memory request handshake and reports the outcome to the LDQ via load_fired / load_fired_tag / load_fired_sleep* / load_fired_forward*.

---
 rtl/load_fire_unit_pkg.sv | 34 +++
 rtl/load_fire_unit_rotated_priority_select.sv | 32 +++
 rtl/load_fire_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_fire_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_fire_unit_pkg.sv
// Shared LSU package for the load fire unit.
//   - default widths used to size the issue-register struct
//   - fire_state_e   : load fire FSM states
//   - issue_reg_t    : one-entry issue register (LDQ tag, address, ROB tag)
//   - rob_younger_or_equal : wrap-aware ROB age compare, shared with LDQ/STQ
package load_fire_unit_pkg;

  localparam int LSU_XLEN      = 32;
  localparam int LSU_ROB_TAG_W = 5;
  localparam int LSU_LDQ_TAG_W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } fire_state_e;

  typedef struct packed {
    logic [LSU_LDQ_TAG_W-1:0] tag;
    logic [LSU_XLEN-1:0]      address;
    logic [LSU_ROB_TAG_W-1:0] rob_tag;
  } issue_reg_t;

  // ROB tags carry an extra wrap bit, so age is the sign of the modular
  // difference: non-negative means tag is the same as or younger than ref_tag.
  function automatic logic rob_younger_or_equal(
    input logic [LSU_ROB_TAG_W-1:0] tag,
    input logic [LSU_ROB_TAG_W-1:0] ref_tag
  );
    logic [LSU_ROB_TAG_W-1:0] diff;
    diff = tag - ref_tag;
    return !diff[LSU_ROB_TAG_W-1];
  endfunction

endpackage

// File: rtl/load_fire_unit_rotated_priority_select.sv
// Oldest-first picker over a head-rotated eligibility vector.
//   eligible : bit k = entry at (head + k) may fire; bit 0 is the oldest
//   head     : LDQ head tag
//   found    : at least one entry eligible
//   tag      : head + lowest eligible k, in LDQ tag arithmetic (wraps naturally)
module rotated_priority_select
  import load_fire_unit_pkg::*;
#(
  parameter int LDQ_SIZE      = 8,
  parameter int LDQ_TAG_WIDTH = LSU_LDQ_TAG_W
) (
  input  logic [LDQ_SIZE-1:0]      eligible,
  input  logic [LDQ_TAG_WIDTH-1:0] head,
  output logic                     found,
  output logic [LDQ_TAG_WIDTH-1:0] tag
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    found = 1'b0;
    tag   = '0;
    // Scan from youngest to oldest so the lowest set offset is the last write.
    for (int k = LDQ_SIZE - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        found = 1'b1;
        tag   = head + LDQ_TAG_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/load_fire_unit.sv
// Load fire unit: picks the oldest fireable load from the LDQ, holds it in a
// one-entry issue register for the store-queue searcher, issues the memory
// request and reports the outcome (executed / sleep / forward) to the LDQ.
//
// Ports:
//   clk, reset (async, active-low)
//   ldq_rotated_*           : LDQ status vectors, head at bit 0
//   ldq_head, ldq_address, ldq_rob_tag : LDQ head and per-entry payload
//   search_*                : issue-register view and searcher result
//   mem_req_*               : memory load request handshake
//   load_fired*             : LDQ update strobe and outcome
//   flush, flush_rob_tag    : ROB flush, kills held loads same age or younger
//
// Build option LOAD_FIRE_STATS_EN adds 32-bit saturating event counters
// stat_fired_mem, stat_slept, stat_forwarded, stat_flushed.
module load_fire_unit
  import load_fire_unit_pkg::*;
#(
  parameter int XLEN          = LSU_XLEN,
  parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_W,
  parameter int LDQ_SIZE      = 8,
  parameter int LDQ_TAG_WIDTH = LSU_LDQ_TAG_W,
  parameter int STQ_TAG_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_valid,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_address_valid,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_sleeping,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_executed,
  input  logic [LDQ_TAG_WIDTH-1:0]          ldq_head,
  input  logic [LDQ_SIZE*XLEN-1:0]          ldq_address,
  input  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0] ldq_rob_tag,
  output logic                              search_valid,
  output logic [LDQ_TAG_WIDTH-1:0]          search_ldq_tag,
  output logic [XLEN-1:0]                   search_address,
  input  logic                              search_sleep,
  input  logic [ROB_TAG_WIDTH-1:0]          search_sleep_rob_tag,
  input  logic                              search_forward,
  input  logic [STQ_TAG_WIDTH-1:0]          search_forward_stq_tag,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [XLEN-1:0]                   mem_req_address,
  output logic [ROB_TAG_WIDTH-1:0]          mem_req_rob_tag,
  output logic                              load_fired,
  output logic [LDQ_TAG_WIDTH-1:0]          load_fired_tag,
  output logic                              load_fired_sleep,
  output logic [ROB_TAG_WIDTH-1:0]          load_fired_sleep_rob_tag,
  output logic                              load_fired_forward,
  output logic [STQ_TAG_WIDTH-1:0]          load_fired_forward_tag,
  input  logic                              flush,
  input  logic [ROB_TAG_WIDTH-1:0]          flush_rob_tag
`ifdef LOAD_FIRE_STATS_EN
  ,
  output logic [31:0]                       stat_fired_mem,
  output logic [31:0]                       stat_slept,
  output logic [31:0]                       stat_forwarded,
  output logic [31:0]                       stat_flushed
`endif
);

  localparam int IDX_W = $clog2(LDQ_SIZE);

  fire_state_e state, state_next;
  issue_reg_t  held;

  logic [XLEN-1:0]          addr_arr [LDQ_SIZE];
  logic [ROB_TAG_WIDTH-1:0] rob_arr  [LDQ_SIZE];
  logic [LDQ_SIZE-1:0]      held_mask, eligible;
  logic [LDQ_TAG_WIDTH-1:0] held_offset, sel_tag;
  logic [IDX_W-1:0]         sel_idx;
  logic                     found, capture, release_held;
  logic                     kill, fire_sleep, fire_forward, fire_mem;

  for (genvar i = 0; i < LDQ_SIZE; i++) begin : g_unpack
    assign addr_arr[i] = ldq_address[i*XLEN +: XLEN];
    assign rob_arr[i]  = ldq_rob_tag[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
  end

  // The held entry's rotated offset is its distance from the current head;
  // masking it keeps the load from being picked twice while it is in flight
  // (including the release cycle, before the LDQ has seen the update).
  assign held_offset = held.tag - ldq_head;
  assign held_mask   = (state == S_ISSUE) ? (LDQ_SIZE'(1) << held_offset[IDX_W-1:0])
                                          : '0;
  assign eligible    = ldq_rotated_valid & ldq_rotated_address_valid &
                       ~ldq_rotated_sleeping & ~ldq_rotated_executed & ~held_mask;

  rotated_priority_select #(
    .LDQ_SIZE      (LDQ_SIZE),
    .LDQ_TAG_WIDTH (LDQ_TAG_WIDTH)
  ) u_select (
    .eligible (eligible),
    .head     (ldq_head),
    .found    (found),
    .tag      (sel_tag)
  );

  assign sel_idx = sel_tag[IDX_W-1:0];

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Outcome decode: sleep beats forward, forward beats memory; a killed load
  // reports nothing and drops its request regardless of ready.
  always_comb begin
    kill          = 1'b0;
    fire_sleep    = 1'b0;
    fire_forward  = 1'b0;
    mem_req_valid = 1'b0;
    if (state == S_ISSUE) begin
      if (flush && rob_younger_or_equal(held.rob_tag, flush_rob_tag)) kill          = 1'b1;
      else if (search_sleep)                                          fire_sleep    = 1'b1;
      else if (search_forward)                                        fire_forward  = 1'b1;
      else                                                            mem_req_valid = 1'b1;
    end
  end

  assign fire_mem     = mem_req_valid & mem_req_ready;
  assign release_held = fire_sleep | fire_forward | fire_mem;
  // A flush cycle never captures: the candidate may itself be on the killed path.
  assign capture      = found & ~flush & ((state == S_IDLE) | release_held);

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (capture) state_next = S_ISSUE;
      S_ISSUE: begin
        if (kill)              state_next = S_IDLE;
        else if (release_held) state_next = capture ? S_ISSUE : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Issue register. These are ordinary control-path flops, so they are
  // cleared by reset to keep every derived output at zero until a capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held <= '0;
    end else if (capture) begin
      held.tag     <= sel_tag;
      held.address <= addr_arr[sel_idx];
      held.rob_tag <= rob_arr[sel_idx];
    end
  end

  assign search_valid             = (state == S_ISSUE);
  assign search_ldq_tag           = held.tag;
  assign search_address           = held.address;
  assign mem_req_address          = held.address;
  assign mem_req_rob_tag          = held.rob_tag;
  assign load_fired               = release_held;
  assign load_fired_tag           = held.tag;
  assign load_fired_sleep         = fire_sleep;
  assign load_fired_forward       = fire_forward;
  assign load_fired_sleep_rob_tag = fire_sleep   ? search_sleep_rob_tag   : '0;
  assign load_fired_forward_tag   = fire_forward ? search_forward_stq_tag : '0;

`ifdef LOAD_FIRE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fired_mem <= '0;
      stat_slept     <= '0;
      stat_forwarded <= '0;
      stat_flushed   <= '0;
    end else begin
      if (fire_mem     && stat_fired_mem != '1) stat_fired_mem <= stat_fired_mem + 32'd1;
      if (fire_sleep   && stat_slept     != '1) stat_slept     <= stat_slept     + 32'd1;
      if (fire_forward && stat_forwarded != '1) stat_forwarded <= stat_forwarded + 32'd1;
      if (kill         && stat_flushed   != '1) stat_flushed   <= stat_flushed   + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_fire_unit.sv
// Directed self-checking bench for load_fire_unit. A small physical LDQ image
// is kept here and rotated by the head pointer before being driven.
module tb_load_fire_unit;

  localparam int XLEN     = 32;
  localparam int ROB_W    = 5;
  localparam int LDQ_SIZE = 8;
  localparam int LTAG_W   = 4;
  localparam int STAG_W   = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [LDQ_SIZE-1:0]       rot_valid, rot_addr_valid, rot_sleeping, rot_executed;
  logic [LTAG_W-1:0]         ldq_head;
  logic [LDQ_SIZE*XLEN-1:0]  ldq_address;
  logic [LDQ_SIZE*ROB_W-1:0] ldq_rob_tag;
  logic                      search_valid;
  logic [LTAG_W-1:0]         search_ldq_tag;
  logic [XLEN-1:0]           search_address;
  logic                      search_sleep;
  logic [ROB_W-1:0]          search_sleep_rob_tag;
  logic                      search_forward;
  logic [STAG_W-1:0]         search_forward_stq_tag;
  logic                      mem_req_valid, mem_req_ready;
  logic [XLEN-1:0]           mem_req_address;
  logic [ROB_W-1:0]          mem_req_rob_tag;
  logic                      load_fired;
  logic [LTAG_W-1:0]         load_fired_tag;
  logic                      load_fired_sleep;
  logic [ROB_W-1:0]          load_fired_sleep_rob_tag;
  logic                      load_fired_forward;
  logic [STAG_W-1:0]         load_fired_forward_tag;
  logic                      flush;
  logic [ROB_W-1:0]          flush_rob_tag;
`ifdef LOAD_FIRE_STATS_EN
  logic [31:0] stat_fired_mem, stat_slept, stat_forwarded, stat_flushed;
`endif

  // Physical LDQ image.
  logic [LDQ_SIZE-1:0] pv, pav, psl, pex;
  logic [XLEN-1:0]     paddr [LDQ_SIZE];
  logic [ROB_W-1:0]    prob  [LDQ_SIZE];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_fire_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .ldq_rotated_valid         (rot_valid),
    .ldq_rotated_address_valid (rot_addr_valid),
    .ldq_rotated_sleeping      (rot_sleeping),
    .ldq_rotated_executed      (rot_executed),
    .ldq_head                  (ldq_head),
    .ldq_address               (ldq_address),
    .ldq_rob_tag               (ldq_rob_tag),
    .search_valid              (search_valid),
    .search_ldq_tag            (search_ldq_tag),
    .search_address            (search_address),
    .search_sleep              (search_sleep),
    .search_sleep_rob_tag      (search_sleep_rob_tag),
    .search_forward            (search_forward),
    .search_forward_stq_tag    (search_forward_stq_tag),
    .mem_req_valid             (mem_req_valid),
    .mem_req_ready             (mem_req_ready),
    .mem_req_address           (mem_req_address),
    .mem_req_rob_tag           (mem_req_rob_tag),
    .load_fired                (load_fired),
    .load_fired_tag            (load_fired_tag),
    .load_fired_sleep          (load_fired_sleep),
    .load_fired_sleep_rob_tag  (load_fired_sleep_rob_tag),
    .load_fired_forward        (load_fired_forward),
    .load_fired_forward_tag    (load_fired_forward_tag),
    .flush                     (flush),
    .flush_rob_tag             (flush_rob_tag)
`ifdef LOAD_FIRE_STATS_EN
    ,
    .stat_fired_mem            (stat_fired_mem),
    .stat_slept                (stat_slept),
    .stat_forwarded            (stat_forwarded),
    .stat_flushed              (stat_flushed)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rotate the physical image by the head pointer and drive the DUT.
  task automatic apply();
    for (int k = 0; k < LDQ_SIZE; k++) begin
      int p;
      p = (int'(ldq_head) + k) % LDQ_SIZE;
      rot_valid[k]      = pv[p];
      rot_addr_valid[k] = pav[p];
      rot_sleeping[k]   = psl[p];
      rot_executed[k]   = pex[p];
    end
    for (int i = 0; i < LDQ_SIZE; i++) begin
      ldq_address[i*XLEN +: XLEN]   = paddr[i];
      ldq_rob_tag[i*ROB_W +: ROB_W] = prob[i];
    end
  endtask

  task automatic clear_ldq();
    pv = '0; pav = '0; psl = '0; pex = '0;
    ldq_head = '0;
  endtask

  task automatic add_load(input int idx, input logic [ROB_W-1:0] rob);
    pv[idx]   = 1'b1;
    pav[idx]  = 1'b1;
    prob[idx] = rob;
  endtask

  // Inputs change and outputs are sampled 2-3 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    search_sleep = 1'b0; search_sleep_rob_tag = '0;
    search_forward = 1'b0; search_forward_stq_tag = '0;
    mem_req_ready = 1'b0; flush = 1'b0; flush_rob_tag = '0;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      paddr[i] = 32'h1000 + 32'h40 * i;
      prob[i]  = '0;
    end
    clear_ldq();
    apply();

    // Reset state.
    #2;
    check("rst_search_valid", search_valid, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_load_fired", load_fired, 0);
    check("rst_search_tag", search_ldq_tag, 0);
    check("rst_mem_addr", mem_req_address, 0);
    tick();
    reset = 1'b1;

    // Oldest-first with head=4: entry 5 (offset 1) before entry 2 (offset 6, tag 10).
    ldq_head = 4'd4;
    add_load(5, 5'd3);
    add_load(2, 5'd4);
    mem_req_ready = 1'b1;
    apply(); #1;
    check("sel_idle_search_valid", search_valid, 0);
    check("sel_idle_fired", load_fired, 0);
    tick();
    check("sel1_search_valid", search_valid, 1);
    check("sel1_tag", search_ldq_tag, 5);
    check("sel1_addr", mem_req_address, 32'h1140);
    check("sel1_rob", mem_req_rob_tag, 3);
    check("sel1_fired", load_fired, 1);
    check("sel1_fired_tag", load_fired_tag, 5);
    tick();
    pex[5] = 1'b1; apply(); #1;
    check("sel2_tag", search_ldq_tag, 10);
    check("sel2_addr", search_address, 32'h1080);
    check("sel2_fired", load_fired, 1);
    check("sel2_fired_tag", load_fired_tag, 10);
    tick();
    pex[2] = 1'b1; apply(); #1;
    check("sel_done_idle", search_valid, 0);
    check("sel_done_fired", load_fired, 0);

    // Memory backpressure: request held stable for 4 cycles.
    clear_ldq();
    add_load(3, 5'd5);
    mem_req_ready = 1'b0;
    apply();
    tick();
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", mem_req_valid, 1);
      check("stall_addr", mem_req_address, 32'h10c0);
      check("stall_fired", load_fired, 0);
      tick();
    end
    mem_req_ready = 1'b1; #1;
    check("stall_ready_valid", mem_req_valid, 1);
    check("stall_ready_addr", mem_req_address, 32'h10c0);
    check("stall_ready_fired", load_fired, 1);
    check("stall_ready_tag", load_fired_tag, 3);
    tick();
    pex[3] = 1'b1; apply(); #1;
    check("stall_done_idle", search_valid, 0);

    // Store-to-load forwarding outcome.
    clear_ldq();
    add_load(6, 5'd2);
    apply();
    tick();
    search_forward = 1'b1; search_forward_stq_tag = 4'd3; #1;
    check("fwd_fired", load_fired, 1);
    check("fwd_flag", load_fired_forward, 1);
    check("fwd_tag", load_fired_forward_tag, 3);
    check("fwd_sleep", load_fired_sleep, 0);
    check("fwd_mem_valid", mem_req_valid, 0);
    tick();
    search_forward = 1'b0; search_forward_stq_tag = '0;
    pex[6] = 1'b1; apply(); #1;
    check("fwd_done_idle", search_valid, 0);

    // Sleep outcome; sleep wins over a simultaneous forward.
    clear_ldq();
    add_load(1, 5'd8);
    apply();
    tick();
    search_sleep = 1'b1; search_sleep_rob_tag = 5'h07; search_forward = 1'b1; #1;
    check("slp_fired", load_fired, 1);
    check("slp_flag", load_fired_sleep, 1);
    check("slp_rob_tag", load_fired_sleep_rob_tag, 7);
    check("slp_fwd_flag", load_fired_forward, 0);
    check("slp_mem_valid", mem_req_valid, 0);
    tick();
    search_sleep = 1'b0; search_sleep_rob_tag = '0; search_forward = 1'b0;
    psl[1] = 1'b1; apply(); #1;
    check("slp_not_resel1", search_valid, 0);
    tick();
    check("slp_not_resel2", search_valid, 0);
    psl[1] = 1'b0; apply();
    tick();
    check("wake_tag", search_ldq_tag, 1);
    check("wake_fired", load_fired, 1);
    tick();
    pex[1] = 1'b1; apply();

    // Flush kills a younger held load; no capture during the flush cycle.
    clear_ldq();
    add_load(4, 5'd9);
    apply();
    tick();
    flush = 1'b1; flush_rob_tag = 5'd7;
    add_load(2, 5'd1); apply(); #1;
    check("kill_fired", load_fired, 0);
    check("kill_mem_valid", mem_req_valid, 0);
    tick();
    flush = 1'b0; pv[4] = 1'b0; apply(); #1;
    check("kill_idle", search_valid, 0);
    tick();
    check("post_kill_tag", search_ldq_tag, 2);
    check("post_kill_fired", load_fired, 1);
    tick();
    pex[2] = 1'b1; apply();

    // Flush does not touch an older held load.
    clear_ldq();
    add_load(5, 5'd6);
    apply();
    tick();
    flush = 1'b1; flush_rob_tag = 5'd7; #1;
    check("survive_mem_valid", mem_req_valid, 1);
    check("survive_fired", load_fired, 1);
    check("survive_tag", load_fired_tag, 5);
    tick();
    flush = 1'b0; pex[5] = 1'b1; apply(); #1;
    check("survive_done_idle", search_valid, 0);

    // Reset in the middle of a stalled handshake.
    clear_ldq();
    add_load(7, 5'd10);
    mem_req_ready = 1'b0;
    apply();
    tick();
    check("prerst_mem_valid", mem_req_valid, 1);
    reset = 1'b0; #1;
    check("midrst_mem_valid", mem_req_valid, 0);
    check("midrst_search_valid", search_valid, 0);
    check("midrst_addr", mem_req_address, 0);
    check("midrst_rob", mem_req_rob_tag, 0);
    check("midrst_tag", search_ldq_tag, 0);
    tick();
    reset = 1'b1; #1;
    check("postrst_idle", search_valid, 0);
    tick();
    check("postrst_reselect", search_valid, 1);
    check("postrst_tag", search_ldq_tag, 7);
    mem_req_ready = 1'b1; #1;
    check("postrst_fired", load_fired, 1);
    tick();
    pex[7] = 1'b1; apply(); #1;

`ifdef LOAD_FIRE_STATS_EN
    // Counters were cleared by the mid-handshake reset; one memory fire since.
    check("stat_fired_mem", stat_fired_mem, 1);
    check("stat_slept", stat_slept, 0);
    check("stat_forwarded", stat_forwarded, 0);
    check("stat_flushed", stat_flushed, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
